// File: rtl/rr_pkt_sched_pkg.sv
// arb_pkg: shared types and helpers for the round-robin packet scheduler.
//   sched_state_e : scheduler FSM states (IDLE, LOCK)
//   therm_above   : mask of bits strictly above idx, limited to n bits
//   lowest_idx    : index of the lowest set bit of a vector (0 if none)
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_state_e;

  // Helpers operate on a fixed maximum width; callers cast to their own width.
  localparam int MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] therm_above(input int idx, input int n);
    logic [MAX_REQ-1:0] m;
    m = {MAX_REQ{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      m[i] = ((i > idx) && (i < n)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  function automatic int lowest_idx(input logic [MAX_REQ-1:0] vec);
    int r;
    r = 0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      r = vec[i] ? i : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pkt_sched_if.sv
// rr_pkt_sched_if: requester-side and sink-side handshake bundle.
//   req_valid/req_data/req_last/req_ready : per-requester valid/ready beats
//   out_valid/out_ready/out_data/out_last/out_src : registered output beat
//   pri_mask : current thermometer priority mask (debug/coverage)
// modport slave is the scheduler side, modport master the environment side.
interface rr_pkt_sched_if #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDX_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]            req_valid;
  logic [REQ_NUM*DATA_WIDTH-1:0] req_data;
  logic [REQ_NUM-1:0]            req_last;
  logic [REQ_NUM-1:0]            req_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_last;
  logic [IDX_W-1:0]              out_src;
  logic [REQ_NUM-1:0]            pri_mask;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, pri_mask
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, pri_mask
  );
endinterface

// File: rtl/rr_pkt_sched_pick.sv
// rr_pick: combinational two-pass round-robin pick.
//   req  : request vector
//   mask : thermometer priority mask
//   gnt  : one-hot grant (zero when no request)
//   idx  : index of the granted requester (0 when no request)
// The masked (high-priority) group wins if non-empty, else the plain lowest request.
module rr_pick
  import arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  localparam int IDX_W  = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [REQ_NUM-1:0] mask,
  output logic [REQ_NUM-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [REQ_NUM-1:0] masked_s;
  logic [REQ_NUM-1:0] cand_s;

  // Select candidate set, then take its lowest index.
  always_comb begin
    masked_s = req & mask;
    if (masked_s != {REQ_NUM{1'b0}}) begin
      cand_s = masked_s;
    end else begin
      cand_s = req;
    end
    idx = IDX_W'(lowest_idx(MAX_REQ'(cand_s)));
    if (cand_s != {REQ_NUM{1'b0}}) begin
      gnt = {{(REQ_NUM-1){1'b0}}, 1'b1} << idx;
    end else begin
      gnt = {REQ_NUM{1'b0}};
    end
  end

endmodule

// File: rtl/rr_pkt_sched.sv
// rr_pkt_sched: round-robin packet scheduler with packet locking.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : rr_pkt_sched_if.slave (requester beats in, registered beat out,
//          pri_mask debug output)
// A winner is picked every cycle; a multi-beat packet keeps its owner until
// the last beat, and priority moves past the winner only when a packet ends.
module rr_pkt_sched
  import arb_pkg::*;
#(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_pkt_sched_if.slave bus
);

  localparam int IDX_W = $clog2(REQ_NUM);

  sched_state_e          state_r, state_nxt_s;
  logic [IDX_W-1:0]      owner_r, owner_nxt_s;
  logic [REQ_NUM-1:0]    pri_mask_r, pri_mask_nxt_s;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_last_r;
  logic [IDX_W-1:0]      out_src_r;

  logic                  ld_s;
  logic [REQ_NUM-1:0]    pick_gnt_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  win_valid_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  accept_s;
  logic [REQ_NUM-1:0]    req_ready_s;
  logic [DATA_WIDTH-1:0] acc_data_s;
  logic                  acc_last_s;

  // Output stage can take a new beat when empty or draining this cycle.
  assign ld_s = ~out_valid_r | bus.out_ready;

  rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .req  (bus.req_valid),
    .mask (pri_mask_r),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s)
  );

  // Winner selection and ready generation; a locked owner without valid is a bubble.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    case (state_r)
      IDLE: begin
        win_valid_s = |pick_gnt_s;
        win_idx_s   = pick_idx_s;
      end
      LOCK: begin
        win_valid_s = bus.req_valid[owner_r];
        win_idx_s   = owner_r;
      end
      default: begin
        win_valid_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
      end
    endcase
    accept_s    = ld_s & win_valid_s;
    req_ready_s = {REQ_NUM{1'b0}};
    if (accept_s) begin
      req_ready_s[win_idx_s] = 1'b1;
    end else begin
      req_ready_s = {REQ_NUM{1'b0}};
    end
    acc_data_s = bus.req_data[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
    acc_last_s = bus.req_last[win_idx_s];
  end

  // Next state, owner and priority mask; mask moves only on a last beat.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    pri_mask_nxt_s = pri_mask_r;
    if (accept_s) begin
      if (acc_last_s) begin
        state_nxt_s    = IDLE;
        // All-zero mask after the top requester falls back to the plain pick.
        pri_mask_nxt_s = REQ_NUM'(therm_above(int'(win_idx_s), REQ_NUM));
      end else begin
        state_nxt_s = LOCK;
        owner_nxt_s = win_idx_s;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM, owner, mask and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= {IDX_W{1'b0}};
      pri_mask_r  <= {REQ_NUM{1'b1}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      out_src_r   <= {IDX_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      owner_r    <= owner_nxt_s;
      pri_mask_r <= pri_mask_nxt_s;
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= acc_data_s;
        out_last_r  <= acc_last_s;
        out_src_r   <= win_idx_s;
      end else if (ld_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_src   = out_src_r;
  assign bus.pri_mask  = pri_mask_r;

endmodule

// File: doc/rr_pkt_sched.md
# rr_pkt_sched

Round-robin packet scheduler that shares one output datapath between `REQ_NUM` valid/ready requesters. It holds a thermometer priority mask, picks a winner each cycle and locks the winner for multi-beat packets until the `last` beat. It registers the selected beat into a single output stage and advances priority past the winner when its packet completes. It sits in front of any shared sink: a bus port, FIFO write side or downstream arbiter tree.

## Interface
- `REQ_NUM`, 4, number of requesters (>= 2, need not be a power of two)
- `DATA_WIDTH`, 8, beat width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  REQ_NUM  per-requester beat valid
- `req_data`  in  REQ_NUM*DATA_WIDTH  requester i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- `req_last`  in  REQ_NUM  beat is the final beat of its packet
- `req_ready`  out  REQ_NUM  one-hot or zero; beat i accepted when `req_valid[i] & req_ready[i]`
- `out_valid`  out  1  registered output beat valid
- `out_ready`  in  1  sink accepts output beat
- `out_data`  out  DATA_WIDTH  registered winning beat
- `out_last`  out  1  registered copy of winner's `req_last`
- `out_src`  out  $clog2(REQ_NUM)  index of the requester that supplied `out_data`
- `pri_mask`  out  REQ_NUM  current thermometer mask, for debug and coverage

## Operation
- Load enable: `ld = ~out_valid | out_ready`. `req_ready` is all zero when `ld = 0`.
- `pri_mask` is a thermometer code. Bit i = 1 means requester i is in the high-priority group.
- Reset value of `pri_mask` is all ones.
- IDLE pick:
  - If `req_valid & pri_mask` is non-zero, the winner is its lowest set index.
  - Otherwise the winner is the lowest set index of `req_valid`.
  - No valid request means no winner.
- LOCK pick: the winner is always `owner`. If `req_valid[owner] = 0`, there is no winner (bubble) and no other requester is served.
- `req_ready[winner] = ld`.
- On accept:
  - `out_data`, `out_last` and `out_src` load from the winner.
  - `out_valid` becomes 1.
- If `ld = 1` and nothing is accepted, `out_valid` becomes 0.
- FSM states are IDLE and LOCK:
  - IDLE -> LOCK: accepted beat with `req_last = 0`. `owner` is set to the winner index.
  - LOCK -> LOCK: accepted beat with `req_last = 0`.
  - LOCK -> IDLE: accepted beat with `req_last = 1`.
  - IDLE -> IDLE: accepted single-beat packet (`req_last = 1`), or no accept.
- Priority update happens only when a `last` beat is accepted, in either state, for winner k.
  - `pri_mask <= ~((2 << k) - 1)`, truncated to `REQ_NUM` bits.
  - For k = `REQ_NUM-1` this gives all zeros, which behaves as all ones for the next pick.
- Requesters keep `req_valid` and data stable until accepted. Withdrawing a valid before acceptance is allowed only in IDLE; it has no effect on state.
- Reset mid-packet drops the lock. The partial packet is the sink's concern.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_last = 0`, `out_src = 0`, `pri_mask` all ones, state IDLE, `owner = 0`.
- `req_ready` is combinational from `req_valid`, `pri_mask`, state, `out_valid` and `out_ready`. It has no combinational path from `req_data` or `req_last`.
- Latency: beat accepted at edge N is presented on `out_*` from N+1.
- Throughput: one beat per cycle while `out_ready = 1`.
- Output stalls:
  - While `out_valid & ~out_ready`, all `out_*` hold and all `req_ready = 0`.
  - Back-pressure is full-cycle; no skid buffer.
- Mask/state update and output load occur on the same edge.

## Structure
- Shared package `arb_pkg`:
  - state enum `sched_state_e {IDLE, LOCK}`
  - function `therm_above(idx, n)` returning the mask of bits strictly above `idx`
  - function `lowest_idx(vec)`
- Sub-module `rr_pick`: combinational, inputs `req`, `mask`, outputs one-hot `gnt` and `idx`. It implements the masked/unmasked two-pass lowest-index pick.
- FSM, `owner`, mask and output register live in `rr_pkt_sched`.

## Test plan
All with `REQ_NUM = 4`, `DATA_WIDTH = 8`, `out_ready = 1` unless stated.
- Round-robin: all four requesters send single-beat packets continuously; reset at cycle 0. -> `out_src` sequence 0,1,2,3,0,1; `pri_mask` after first accept = 4'b1110.
- Lock: req1 sends a 3-beat packet (`last` on beat 3) while req0, req2 and req3 are valid. -> `out_src` = 1,1,1, then 2; the mask is not updated until beat 3.
- Locked bubble: owner 2 drops `req_valid` for 2 cycles mid-packet while req0 is valid. -> `req_ready = 0000` and `out_valid = 0` for those cycles; req0 is served only after req2's `last`.
- Back-pressure: `out_ready = 0` for 3 cycles with `out_data = 8'hA5` held. -> `out_*` stable, `req_ready = 0000`; the next beat appears the cycle after `out_ready` rises.
- Wrap: req3 completes; then req0 and req3 are both valid. -> `pri_mask = 0000` and the winner is 0.
- Async reset asserted mid-lock (owner 1, beat 2). -> `out_valid = 0` immediately; after release, with req0 and req1 valid, `out_src = 0`.
